rv32i_instr_encoder: RTL
========================

// Module: rv32i_instr_encoder
// PURPOSE
//  Inverse of the decode-stage control ROM: packs field-level RV32I requests (opcode, funct3, alt bit,
//  regs, 32-bit imm) into 32-bit instruction words. Buffers encoded words in a FIFO and streams them out
//  over valid/ready. Used by the self-test program loader and the bench stimulus path to feed I-memory.
// PARAMETERS
//  DEPTH  4  output FIFO entries (power of 2, >=2)
//  CNT_W  16 width of emitted-word counter
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst          in   1      asynchronous, active-low reset
//  req_valid    in   1      request present
//  req_ready    out  1      request accepted when valid&ready
//  req_opcode   in   7      rv32i_opcode
//  req_funct3   in   3      funct3
//  req_alt      in   1      funct7[5] (sub/sra/srai)
//  req_rd       in   5      destination reg
//  req_rs1      in   5      source reg 1
//  req_rs2      in   5      source reg 2
//  req_imm      in   32     logical immediate (byte offset, not pre-shifted; U-type: full 32-bit value)
//  instr_valid  out  1      encoded word available
//  instr_ready  in   1      consumer takes word when valid&ready
//  instr_data   out  32     encoded instruction (FIFO head)
//  err_illegal  out  1      1-cycle pulse: accepted request had unsupported opcode
//  err_range    out  1      1-cycle pulse: immediate out of range (RANGE_CHECK_EN only)
//  emit_count   out  CNT_W  words handed to consumer, wraps at 2^CNT_W
// BEHAVIOUR
//  - Reset: FIFO empty, instr_valid=0, instr_data=0, err_*=0, emit_count=0; req_ready=1 after release.
//    Reset asserted mid-transfer drops all buffered words; no partial word ever emitted.
//  - req_ready = !full (no same-cycle bypass when full). Accept at edge N -> word pushed at edge N;
//    instr_valid high from cycle N+1 if FIFO was empty (latency 1).
//  - Encoding: lui/auipc U {imm[31:12]}; jal J {imm[20|10:1|11|19:12]}; jalr/load/op_imm I {imm[11:0]};
//    op_imm funct3=001/101: imm[11:5]={1'b0,req_alt,5'b0}, imm[4:0]=shamt; store S; br B {imm[12|10:5],
//    {imm[4:1|11]}}; op_reg R funct7={1'b0,req_alt,5'b0}, alt honoured only for funct3 000/101, else 0.
//  - Unused fields (e.g. rd of S/B) encoded as zero from instruction layout, not from request.
//  - Illegal opcode (incl. op_csr, unknown): request accepted, nothing pushed, err_illegal pulses N+1.
//  - Simultaneous push+pop when FIFO non-empty and not full: occupancy unchanged, order preserved.
//  - Pop when empty impossible (instr_valid=0). instr_data holds head; undefined-free: stays last value.
//  - Pointers wrap modulo DEPTH with extra MSB for full/empty; emit_count increments on each pop.
// CONFIGURATION
//  RANGE_CHECK_EN defined: flags I/S imm not sign-ext of 12 bits, B not 13-bit signed even, J not
//    21-bit signed even, U imm[11:0]!=0, shamt imm[31:5]!=0; word still encoded (truncated) and pushed,
//    err_range pulses cycle N+1.
//  Not defined: silent truncation, err_range tied 0, no check logic.
// STRUCTURE
//  - rv32i_types package: rv32i_opcode, funct3 enums (reused); add instr_fmt_t {R,I,S,B,U,J,SHIFT,ILL}
//    and fmt_of(opcode,funct3) function to shared types package.
//  - Sub-module enc_fifo (DEPTH, 32-bit data) holds storage/pointers; top holds encode, checks, counter.
// TESTING
//  1 addi x1,x0,5 (imm=5), instr_ready=1 -> instr_data=0x00500093 at N+1, emit_count=1.
//  2 sub x3,x1,x2 (alt=1), then srai x1,x1,3 (alt=1) -> 0x402081B3, 0x4030D093 in order.
//  3 lui x5 imm=0x12345000; beq x1,x2,+8; jal x1,+16 -> 0x123452B7, 0x00208463, 0x010000EF.
//  4 instr_ready=0, push DEPTH+1 requests -> req_ready=0 after DEPTH; release -> all DEPTH out in order.
//  5 opcode op_csr -> no push, err_illegal pulse 1 cycle; rst low with 3 buffered -> instr_valid=0, count=0.
//  6 RANGE_CHECK_EN: addi imm=0x800 -> err_range pulse, word 0x80000013 with rd=0,rs1=0; without -> no pulse.

Source files
------------

// File: rtl/rv32i_types.sv
// Package: rv32i_types
// Shared RV32I encoding types: major opcodes, funct3 codes, the instruction
// format classification used by the encoder, and fmt_of(), which maps an
// (opcode, funct3) pair onto the bit layout that packs it.
package rv32i_types;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_MISC   = 7'b0001111,
    OPC_IMM    = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_REG    = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_CSR    = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'b000,
    F3_SLL     = 3'b001,
    F3_SLT     = 3'b010,
    F3_SLTU    = 3'b011,
    F3_XOR     = 3'b100,
    F3_SRL_SRA = 3'b101,
    F3_OR      = 3'b110,
    F3_AND     = 3'b111
  } funct3_t;

  // FMT_SHIFT is the I-type variant whose upper immediate bits carry funct7.
  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_SHIFT,
    FMT_ILL
  } instr_fmt_t;

  // Everything outside the supported base set (CSR/system, fence, unknown)
  // classifies as FMT_ILL.
  function automatic instr_fmt_t fmt_of(input logic [6:0] opcode,
                                        input logic [2:0] funct3);
    instr_fmt_t fmt;
    case (opcode)
      OPC_LUI, OPC_AUIPC: fmt = FMT_U;
      OPC_JAL:            fmt = FMT_J;
      OPC_JALR, OPC_LOAD: fmt = FMT_I;
      OPC_IMM:            fmt = (funct3 == F3_SLL || funct3 == F3_SRL_SRA) ? FMT_SHIFT : FMT_I;
      OPC_STORE:          fmt = FMT_S;
      OPC_BRANCH:         fmt = FMT_B;
      OPC_REG:            fmt = FMT_R;
      default:            fmt = FMT_ILL;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Module: enc_fifo
// Output buffer for encoded words. Pointers carry one extra MSB so full and
// empty are distinguishable when the index bits match.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   i_push       write i_data (ignored when full)
//   i_data       word to store
//   i_pop        drop head (ignored when empty)
//   o_full       no free entry
//   o_empty      no stored entry
//   o_head       head word; holds the last popped word while empty
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [DW-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_last;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // While empty the head shows the last word handed out (zero after reset),
  // never a stale slot from the storage array.
  assign o_head = o_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end
  end

  // NOTE: storage is deliberately not reset; a slot is only ever read after
  // it was written, because reads are gated by the empty flag above.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Module: rv32i_instr_encoder
// Packs field-level RV32I requests into 32-bit instruction words, buffers
// them in enc_fifo and streams them out over a valid/ready handshake.
// Optional build macro: RANGE_CHECK_EN -- flags immediates that do not fit
// their instruction format (the truncated word is still emitted).
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid / req_ready    request handshake (ready = FIFO not full)
//   req_opcode, req_funct3   operation selection
//   req_alt                  funct7[5] for sub/sra/srai
//   req_rd, req_rs1, req_rs2 register fields
//   req_imm                  logical immediate (byte offset; U: full value)
//   instr_valid/instr_ready  output handshake
//   instr_data               FIFO head word
//   err_illegal              pulse: accepted request had unsupported opcode
//   err_range                pulse: immediate out of range (macro only)
//   emit_count               words handed to consumer, wrapping
module rv32i_instr_encoder
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_opcode,
  input  logic [2:0]       req_funct3,
  input  logic             req_alt,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [31:0]      req_imm,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr_data,
  output logic             err_illegal,
  output logic             err_range,
  output logic [CNT_W-1:0] emit_count
);

  instr_fmt_t       w_fmt;
  logic [31:0]      w_word;
  logic             w_alt_r;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             r_err_illegal;
  logic [CNT_W-1:0] r_emit_count;

  assign w_fmt    = fmt_of(req_opcode, req_funct3);
  assign req_ready = !w_full;
  assign w_accept = req_valid && req_ready;
  assign w_push   = w_accept && (w_fmt != FMT_ILL);
  assign w_pop    = instr_valid && instr_ready;

  // Register-register alt bit only exists for add/sub and srl/sra.
  assign w_alt_r = req_alt && (req_funct3 == F3_ADD_SUB || req_funct3 == F3_SRL_SRA);

  // NOTE: the default assignment before the case keeps this block purely
  // combinational; without it an uncovered path would infer a latch.
  always_comb begin
    w_word = '0;
    case (w_fmt)
      FMT_R:     w_word = {1'b0, w_alt_r, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, req_opcode};
      FMT_SHIFT: w_word = {1'b0, req_alt, 5'b0, req_imm[4:0], req_rs1, req_funct3, req_rd, req_opcode};
      FMT_I:     w_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
      FMT_S:     w_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_opcode};
      FMT_B:     w_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                           req_imm[4:1], req_imm[11], req_opcode};
      FMT_U:     w_word = {req_imm[31:12], req_rd, req_opcode};
      FMT_J:     w_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                           req_rd, req_opcode};
      default:   w_word = '0;
    endcase
  end

  enc_fifo #(
    .DEPTH (DEPTH),
    .DW    (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (instr_data)
  );

  assign instr_valid = !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_illegal <= 1'b0;
      r_emit_count  <= '0;
    end else begin
      r_err_illegal <= w_accept && (w_fmt == FMT_ILL);
      if (w_pop) r_emit_count <= r_emit_count + CNT_W'(1);
    end
  end

  assign err_illegal = r_err_illegal;
  assign emit_count  = r_emit_count;

`ifdef RANGE_CHECK_EN
  logic w_range_bad;
  logic r_err_range;

  // Sign-extension checks: the bits above the field's sign bit must all
  // equal that sign bit; branch/jump offsets must also be even.
  always_comb begin
    w_range_bad = 1'b0;
    case (w_fmt)
      FMT_I, FMT_S: w_range_bad = !((&req_imm[31:11]) || !(|req_imm[31:11]));
      FMT_B:        w_range_bad = !((&req_imm[31:12]) || !(|req_imm[31:12])) || req_imm[0];
      FMT_J:        w_range_bad = !((&req_imm[31:20]) || !(|req_imm[31:20])) || req_imm[0];
      FMT_U:        w_range_bad = |req_imm[11:0];
      FMT_SHIFT:    w_range_bad = |req_imm[31:5];
      default:      w_range_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err_range <= 1'b0;
    else      r_err_range <= w_push && w_range_bad;
  end

  assign err_range = r_err_range;
`else
  assign err_range = 1'b0;
`endif

endmodule
